// File: rtl/gpr_dump.sv
// rtl/gpr_dump.sv - register file readout engine streaming (index, value) beats
//
// Walks the inclusive register range [i_first_reg, i_last_reg] through one
// combinational read port of the register file and presents each register
// as one beat on a valid/ready stream.
//
// Ports:
//   i_clk        clock, all state updates on posedge
//   i_rst        asynchronous active-high reset
//   i_start      dump request, sampled only while idle
//   i_first_reg  first index of the range, sampled with i_start
//   i_last_reg   last index of the range (inclusive), sampled with i_start
//   o_rd_addr    register file read address
//   i_rd_data    combinational read data for o_rd_addr
//   o_out_valid  beat available on o_out_idx/o_out_data
//   i_out_ready  sink accepts the beat
//   o_out_idx    register index of the current beat
//   o_out_data   register value of the current beat
//   o_busy       high from start acceptance until the end of the done cycle
//   o_done       one-cycle pulse at the end of a dump
module gpr_dump #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_first_reg,
  input  logic [AW-1:0] i_last_reg,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [AW-1:0] o_out_idx,
  output logic [DW-1:0] o_out_data,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_last;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_out_idx;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic          w_range_ok;
  logic          w_at_end;
  logic          w_busy;
  logic          w_done;

  assign w_range_ok = (i_first_reg <= i_last_reg);
  // Termination is an equality compare so the index never increments past the
  // last register; the top-of-file compare only matters for an out-of-range Last.
  assign w_at_end   = (r_out_idx == r_last) || (r_out_idx == AW'(NREG - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_next = w_range_ok ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        if (i_out_ready) begin
          w_next = w_at_end ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last      <= '0;
      r_rd_addr   <= '0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_last <= i_last_reg;
            if (w_range_ok) begin
              r_rd_addr <= i_first_reg;
            end
          end
        end
        S_LOAD: begin
          // Sampled at this edge: a write landing on the same edge is not seen.
          r_out_data  <= i_rd_data;
          r_out_idx   <= r_rd_addr;
          r_out_valid <= 1'b1;
        end
        S_SEND: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (!w_at_end) begin
              r_rd_addr <= r_out_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rd_addr   = r_rd_addr;
  assign o_out_valid = r_out_valid;
  assign o_out_idx   = r_out_idx;
  assign o_out_data  = r_out_data;
  assign o_busy      = w_busy;
  assign o_done      = w_done;

endmodule

// File: tb/tb_gpr_dump.sv
// tb/tb_gpr_dump.sv - self-checking bench for gpr_dump
module tb_gpr_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] gpr [32];
  logic        wr_en = 1'b0;
  logic [4:0]  wr_idx = '0;
  logic [31:0] wr_data = '0;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0]  exp_idx [$];
  logic [31:0] exp_dat [$];
  logic [4:0]  got_idx [$];
  logic [31:0] got_dat [$];

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         n;
    int         lat;
  } vec_t;
  vec_t tbl [6];

  gpr_dump #(.NREG(32), .AW(5), .DW(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_first_reg(first_reg),
    .i_last_reg (last_reg),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_idx  (out_idx),
    .o_out_data (out_data),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  // Register file model: synchronous write, combinational read.
  always @(posedge clk) if (wr_en) gpr[wr_idx] <= wr_data;
  assign rd_data = gpr[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: records accepted beats, checks hold-while-stalled.
  logic        stalled = 1'b0;
  logic [4:0]  s_idx = '0;
  logic [31:0] s_dat = '0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (done) chk("done_with_valid", 32'(out_valid), 0);
      if (stalled) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_idx", 32'(out_idx), 32'(s_idx));
        chk("hold_data", out_data, s_dat);
      end
      if (out_valid && out_ready) begin
        got_idx.push_back(out_idx);
        got_dat.push_back(out_data);
      end
      stalled = out_valid && !out_ready;
      s_idx = out_idx;
      s_dat = out_data;
    end
  end

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] dat);
    wr_en = 1'b1;
    wr_idx = idx;
    wr_data = dat;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic preload_pattern();
    for (int i = 0; i < 32; i++) write_reg(5'(i), 32'hA500_0000 + 32'(i));
  endtask

  task automatic preload_random();
    for (int i = 0; i < 32; i++) write_reg(5'(i), $urandom);
  endtask

  // Expected stream: every index in the inclusive range, in order, with the
  // register contents as they stand now.
  task automatic build_exp(input logic [4:0] f, input logic [4:0] l);
    exp_idx.delete();
    exp_dat.delete();
    for (int i = int'(f); i <= int'(l); i++) begin
      exp_idx.push_back(5'(i));
      exp_dat.push_back(gpr[i]);
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk($sformatf("%s_count", tag), 32'(got_idx.size()), 32'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), 32'(got_idx[i]), 32'(exp_idx[i]));
      chk($sformatf("%s_data%0d", tag, i), got_dat[i], exp_dat[i]);
    end
  endtask

  // lat = clock edges after the Start edge until Done is observed high.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit rnd,
                          input bit noise, output int lat, output bit busy_ok);
    int stall;
    got_idx.delete();
    got_dat.delete();
    first_reg = f;
    last_reg = l;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    busy_ok = busy;
    lat = 0;
    stall = 0;
    while (!done && lat < 3000) begin
      if (!busy) busy_ok = 1'b0;
      if (rnd) begin
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else if ($urandom_range(0, 7) == 0) begin
          out_ready = 1'b0;
          stall = 4;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      if (noise) begin
        start = ($urandom_range(0, 4) == 0);
        first_reg = 5'($urandom);
        last_reg = 5'($urandom);
      end
      tick();
      lat++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_timeout", 32'(lat < 3000), 1);
    chk("busy_at_done", 32'(busy), 1);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit bok;
    bit rnd;
    logic [4:0] f;
    logic [4:0] l;

    tbl[0] = '{5'd0,  5'd31, 32, 64};
    tbl[1] = '{5'd31, 5'd31, 1,  2};
    tbl[2] = '{5'd7,  5'd2,  0,  0};
    tbl[3] = '{5'd0,  5'd0,  1,  2};
    tbl[4] = '{5'd3,  5'd5,  3,  6};
    tbl[5] = '{5'd31, 5'd0,  0,  0};

    tick();
    tick();
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;

    preload_pattern();
    for (int v = 0; v < 6; v++) begin
      build_exp(tbl[v].f, tbl[v].l);
      run_dump(tbl[v].f, tbl[v].l, 1'b0, 1'b0, lat, bok);
      chk($sformatf("tbl%0d_beats", v), 32'(got_idx.size()), 32'(tbl[v].n));
      chk($sformatf("tbl%0d_latency", v), 32'(lat), 32'(tbl[v].lat));
      chk($sformatf("tbl%0d_busy", v), 32'(bok), 1);
      cmp_stream($sformatf("tbl%0d", v));
    end

    // Backpressure with random ready including 5-cycle stalls.
    for (int r = 0; r < 3; r++) begin
      build_exp(5'd3, 5'd5);
      run_dump(5'd3, 5'd5, 1'b1, 1'b0, lat, bok);
      cmp_stream($sformatf("bp%0d", r));
    end

    // Start pulses while busy must be ignored.
    build_exp(5'd8, 5'd15);
    run_dump(5'd8, 5'd15, 1'b1, 1'b1, lat, bok);
    cmp_stream("noise");

    // Concurrent writes: gpr[4] written on the edge ending its LOAD keeps the
    // old value; gpr[6] written early shows the new value.
    build_exp(5'd0, 5'd7);
    exp_dat[6] = 32'h6666_6666;
    got_idx.delete();
    got_dat.delete();
    first_reg = 5'd0;
    last_reg = 5'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      wr_en = 1'b0;
      if (c == 0) chk("load_no_valid", 32'(out_valid), 0);
      if (c == 1) chk("first_valid", 32'(out_valid), 1);
      if (c == 2) begin
        wr_en = 1'b1; wr_idx = 5'd6; wr_data = 32'h6666_6666;
      end
      if (c == 8) begin
        chk("load4_addr", 32'(rd_addr), 4);
        wr_en = 1'b1; wr_idx = 5'd4; wr_data = 32'hDEAD_BEEF;
      end
      tick();
    end
    wr_en = 1'b0;
    chk("wr_done", 32'(done), 1);
    tick();
    cmp_stream("wr");

    // Reset during SEND of idx 10.
    first_reg = 5'd0;
    last_reg = 5'd31;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 21; c++) tick();
    chk("pre_rst_idx", 32'(out_idx), 10);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_addr", 32'(rd_addr), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_idx", 32'(out_idx), 0);
    chk("arst_data", out_data, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    tick();
    tick();
    chk("arst_done_held", 32'(done), 0);
    rst = 1'b0;
    build_exp(5'd0, 5'd31);
    run_dump(5'd0, 5'd31, 1'b0, 1'b0, lat, bok);
    chk("post_rst_latency", 32'(lat), 64);
    cmp_stream("post_rst");

    // Random ranges and contents against the range model.
    for (int k = 0; k < 12; k++) begin
      preload_random();
      f = 5'($urandom_range(0, 31));
      l = 5'($urandom_range(0, 31));
      rnd = 1'($urandom_range(0, 1));
      build_exp(f, l);
      run_dump(f, l, rnd, 1'b1, lat, bok);
      chk($sformatf("rnd%0d_busy", k), 32'(bok), 1);
      if (!rnd) chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'(2 * exp_idx.size()));
      cmp_stream($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
